// File: rtl/stall_mem_pkg.sv
// Shared types and defaults for the stall_mem block: FSM states, counter width,
// default miss latency and word-address width.
package stall_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int CNT_W       = 4;
    localparam int DW          = 16;
    localparam int DEF_LATENCY = 4;
    localparam int DEF_AW      = 10;

    // The first BUSY cycle already counts, so the counter starts one below the latency.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/stall_mem_array.sv
// Word storage for stall_mem: 2^AW x 16-bit, synchronous write, combinational read.
module stall_mem_array
    import stall_mem_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    // Contents survive reset on purpose, so there is no reset on this array.
    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/stall_mem.sv
// Stalling single-port memory with a fixed miss latency and error responses.
// Optional one-entry read-hit tag is enabled by defining STALL_MEM_HIT_EN.
module stall_mem
    import stall_mem_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int AW      = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   Addr,
    input  logic [15:0]   DataIn,
    input  logic          Rd,
    input  logic          Wr,
    input  logic          createdump,
    output logic [15:0]   DataOut,
    output logic          Done,
    output logic          Stall,
    output logic          CacheHit,
    output logic          err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    din_q, din_d;
    logic             wr_op_q, wr_op_d;
    logic [DW-1:0]    data_q, data_d;
    logic             err_q, err_d;
    logic             hit_q, hit_d;

    logic             req;
    logic             bad_req;
    logic [AW-1:0]    word_addr;
    logic             hit_now;
    logic             commit;
    logic             mem_we;
    logic [DW-1:0]    mem_rdata;
    logic             unused_ok;

    assign req       = Rd | Wr;
    assign bad_req   = (Rd & Wr) | Addr[0];
    assign word_addr = Addr[AW:1];
    assign commit    = (state_q == ST_BUSY) && (cnt_q == '0);
    assign mem_we    = commit & wr_op_q;
    assign unused_ok = ^{createdump, Addr};

`ifdef STALL_MEM_HIT_EN
    logic          tag_valid_q;
    logic [AW-1:0] tag_addr_q;
    logic [DW-1:0] tag_data_q;

    assign hit_now = tag_valid_q & Rd & ~Wr & ~Addr[0] & (tag_addr_q == word_addr);

    // Tag tracks the last completed miss-path access; error responses never touch it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_valid_q <= 1'b0;
            tag_addr_q  <= '0;
            tag_data_q  <= '0;
        end else if (commit) begin
            tag_valid_q <= 1'b1;
            tag_addr_q  <= addr_q;
            tag_data_q  <= wr_op_q ? din_q : mem_rdata;
        end
    end
`else
    assign hit_now = 1'b0;
`endif

    stall_mem_array #(.AW(AW)) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (din_q),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            wr_op_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wr_op_q <= wr_op_d;
            data_q  <= data_d;
            err_q   <= err_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        wr_op_d = wr_op_q;
        data_d  = data_q;
        err_d   = err_q;
        hit_d   = hit_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (bad_req) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        hit_d   = 1'b0;
                        data_d  = '0;
                    end else if (hit_now) begin
                        state_d = ST_RESP;
                        err_d   = 1'b0;
                        hit_d   = 1'b1;
`ifdef STALL_MEM_HIT_EN
                        data_d  = tag_data_q;
`else
                        data_d  = '0;
`endif
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = lat_load(LATENCY);
                        addr_d  = word_addr;
                        din_d   = DataIn;
                        wr_op_d = Wr;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    // Write responses carry no data; reads return the word seen at commit.
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    hit_d   = 1'b0;
                    data_d  = wr_op_q ? '0 : mem_rdata;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Done     = (state_q == ST_RESP);
    assign Stall    = ((state_q == ST_IDLE) & req) | (state_q == ST_BUSY);
    assign DataOut  = Done ? data_q : '0;
    assign err      = Done & err_q;
    assign CacheHit = Done & hit_q;

endmodule
